// File: rtl/calc_seq_pkg.sv
// calc_seq_pkg: shared key codes, ALU opcodes, FSM states and width defaults for the calculator sequencer
package calc_seq_pkg;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_OP_W = 3;
  localparam int DEF_TIMEOUT = 255;
  localparam logic [3:0] K_ADD = 4'd10;
  localparam logic [3:0] K_SUB = 4'd11;
  localparam logic [3:0] K_MUL = 4'd12;
  localparam logic [3:0] K_DIV = 4'd13;
  localparam logic [3:0] K_EQ = 4'd14;
  localparam logic [3:0] K_CLR = 4'd15;
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  typedef enum logic [2:0] {
    S_ENTER_A, S_OP_PEND, S_ENTER_B, S_ISSUE, S_WAIT_ALU, S_SHOW, S_ERROR
  } state_t;
endpackage

// File: rtl/calc_sequencer_dec_accum.sv
// dec_accum: combinational val*10+digit with overflow flag
module dec_accum #(
  parameter int W = 16
) (
  input  logic [W-1:0] val,
  input  logic [3:0]   digit,
  output logic [W-1:0] sum,
  output logic         ovf
);
  logic [W+3:0] full;
  assign full = {4'd0, val} * (W+4)'(10) + {{W{1'b0}}, digit};
  assign sum = full[W-1:0];
  assign ovf = |full[W+3:W];
endmodule

// File: rtl/calc_sequencer.sv
// calc_sequencer: key-driven operand builder issuing ALU operations over a start/done handshake
module calc_sequencer
  import calc_seq_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int OP_W = DEF_OP_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              key_valid,
  input  logic [3:0]        key_code,
  output logic [7:0]        SRCH,
  output logic [7:0]        SRCL,
  output logic [7:0]        DSTH,
  output logic [7:0]        DSTL,
  output logic [OP_W-1:0]   ALU_OP,
  output logic              alu_start,
  input  logic              alu_done,
  input  logic              alu_err,
  input  logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] disp_value,
  output logic              disp_err,
  output logic              busy
);
  localparam int TW = $clog2(TIMEOUT + 1);
  state_t st, st_n;
  logic [DATA_W-1:0] a, a_n, b, b_n, a_acc, b_acc;
  logic [OP_W-1:0] op, op_n, nop, nop_n, kop;
  logic chain, chain_n, pclr, pclr_n, a_ovf, b_ovf;
  logic dig, opk, eq, clr, in_busy, fin;
  logic [TW-1:0] cnt, cnt_n;
  dec_accum #(.W(DATA_W)) u_acc_a (.val(a), .digit(key_code), .sum(a_acc), .ovf(a_ovf));
  dec_accum #(.W(DATA_W)) u_acc_b (.val(b), .digit(key_code), .sum(b_acc), .ovf(b_ovf));
  assign dig = key_valid && key_code < K_ADD;
  assign opk = key_valid && key_code >= K_ADD && key_code <= K_DIV;
  assign eq = key_valid && key_code == K_EQ;
  assign clr = key_valid && key_code == K_CLR;
  assign kop = OP_W'(key_code - K_ADD);
  assign in_busy = st == S_ISSUE || st == S_WAIT_ALU;
  assign fin = st == S_WAIT_ALU && (alu_done || cnt == TW'(TIMEOUT - 1));
  always_comb begin
    st_n = st;
    a_n = a;
    b_n = b;
    op_n = op;
    nop_n = nop;
    chain_n = chain;
    pclr_n = pclr;
    cnt_n = '0;
    case (st)
      S_ENTER_A: begin
        if (dig && !a_ovf) a_n = a_acc;
        else if (opk) begin
          op_n = kop;
          st_n = S_OP_PEND;
        end
      end
      S_OP_PEND: begin
        if (dig) begin
          b_n = DATA_W'(key_code);
          st_n = S_ENTER_B;
        end else if (opk) op_n = kop;
      end
      S_ENTER_B: begin
        if (dig && !b_ovf) b_n = b_acc;
        else if (opk || eq) begin
          chain_n = opk;
          nop_n = opk ? kop : nop;
          st_n = S_ISSUE;
        end
      end
      S_ISSUE: st_n = S_WAIT_ALU;
      S_WAIT_ALU: begin
        cnt_n = cnt + 1'b1;
        if (fin && (!alu_done || alu_err)) st_n = S_ERROR;
        else if (fin) begin
          a_n = alu_result;
          op_n = chain ? nop : op;
          st_n = chain ? S_OP_PEND : S_SHOW;
        end
      end
      S_SHOW: begin
        if (dig) begin
          a_n = DATA_W'(key_code);
          st_n = S_ENTER_A;
        end else if (opk) begin
          op_n = kop;
          st_n = S_OP_PEND;
        end
      end
      default: ;
    endcase
    if (clr && in_busy) pclr_n = 1'b1;
    if ((clr && !in_busy) || (fin && pclr_n)) begin
      st_n = S_ENTER_A;
      a_n = '0;
      b_n = '0;
      op_n = '0;
      pclr_n = 1'b0;
    end
  end
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      st <= S_ENTER_A;
      a <= '0;
      b <= '0;
      op <= '0;
      nop <= '0;
      chain <= 1'b0;
      pclr <= 1'b0;
      cnt <= '0;
      alu_start <= 1'b0;
      busy <= 1'b0;
      disp_err <= 1'b0;
      disp_value <= '0;
    end else begin
      st <= st_n;
      a <= a_n;
      b <= b_n;
      op <= op_n;
      nop <= nop_n;
      chain <= chain_n;
      pclr <= pclr_n;
      cnt <= cnt_n;
      alu_start <= st_n == S_ISSUE;
      busy <= st_n == S_ISSUE || st_n == S_WAIT_ALU;
      disp_err <= st_n == S_ERROR;
      disp_value <= st_n == S_ERROR ? '0 : st_n == S_ENTER_B ? b_n : a_n;
    end
  end
  assign SRCH = a[15:8];
  assign SRCL = a[7:0];
  assign DSTH = b[15:8];
  assign DSTL = b[7:0];
  assign ALU_OP = op;
endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
- Control sequencer between the keyboard/encoder front end and the shared ALU.
- Consumes one-cycle key tokens and builds decimal operands A and B.
- Issues one ALU operation per request through a start/done handshake.
- Chains operators, holds the result for display, and traps ALU errors and timeouts.

Parameters:
DATA_W, 16, operand/result width; SRCH/SRCL/DSTH/DSTL are its byte halves.
OP_W, 3, ALU opcode width.
TIMEOUT, 255, maximum cycles in WAIT_ALU before the error trap.

Ports:
Clock  input  1  system clock; single clock domain.
Reset  input  1  synchronous, active-low reset.
key_valid  input  1  one-cycle strobe; key_code valid.
key_code  input  4  0-9 digit; 10 ADD; 11 SUB; 12 MUL; 13 DIV; 14 EQ; 15 CLR.
SRCH  output  8  operand A [15:8].
SRCL  output  8  operand A [7:0].
DSTH  output  8  operand B [15:8].
DSTL  output  8  operand B [7:0].
ALU_OP  output  OP_W  0 ADD, 1 SUB, 2 MUL, 3 DIV.
alu_start  output  1  one-cycle request pulse.
alu_done  input  1  one-cycle completion pulse.
alu_err  input  1  error flag, qualified by alu_done (overflow, divide by zero).
alu_result  input  DATA_W  result, qualified by alu_done.
disp_value  output  DATA_W  value to display.
disp_err  output  1  error indicator.
busy  output  1  high in ISSUE and WAIT_ALU.

Behaviour:
Reset
- Reset low at a Clock edge: state ENTER_A; A, B, op and pending-clear cleared to 0.
- All outputs 0.
- Applies mid-operation; a later alu_done is ignored.

States: ENTER_A, OP_PEND, ENTER_B, ISSUE, WAIT_ALU, SHOW, ERROR.

Digit entry
- Digit updates the operand to op*10+d.
- If the result exceeds 2^DATA_W-1, the digit is dropped and the operand is unchanged.

Transitions per state
- ENTER_A: digit accumulates into A. Operator latches op and goes to OP_PEND. EQ is ignored.
- OP_PEND: digit sets B=d and goes to ENTER_B. Operator replaces op. EQ is ignored.
- ENTER_B: digit accumulates into B. Operator or EQ goes to ISSUE; the chain flag records which one it was, and a new operator is held in next_op.
- ISSUE: exactly one cycle. alu_start=1, then WAIT_ALU.
- WAIT_ALU: alu_done is sampled only here; the earliest accepted is the cycle after the alu_start pulse.
  - done & alu_err: go to ERROR.
  - done & !alu_err: A = alu_result. If chained, op = next_op and go to OP_PEND; otherwise go to SHOW.
  - Cycle counter reaching TIMEOUT: go to ERROR.
- SHOW: digit sets A=d and goes to ENTER_A. Operator uses A (the result), latches op and goes to OP_PEND. EQ is ignored.
- ERROR: disp_err=1 and disp_value=0. Only CLR exits.

CLR
- In any state except ISSUE/WAIT_ALU: next cycle clears A, B and op, deasserts disp_err, and goes to ENTER_A.
- In ISSUE/WAIT_ALU: sets pending_clear. On done or timeout, the block goes to ENTER_A cleared, and the result/error is discarded.
- Other keys while busy are dropped.

Handshake and outputs
- SRC*/DST*/ALU_OP are stable from the ISSUE cycle through the done cycle inclusive.
- Key accepted at cycle t: registers updated at t+1, alu_start high in t+1.
- alu_done at cycle d: new state and disp_value visible at d+1.
- disp_value: A in ENTER_A, OP_PEND and SHOW; B in ENTER_B; A (the operands being held) in ISSUE and WAIT_ALU.

Decomposition:
- Package calc_seq_pkg: key code constants, ALU opcode constants, state enum, DATA_W/OP_W defaults.
- Sub-module dec_accum: combinational op*10+d with overflow flag; used for both A and B.

Test Plan:
- Keys 1,2,ADD,3,EQ; ALU returns 15 two cycles after start -> ALU_OP=0, SRCL=0x0C, DSTL=0x03, one alu_start pulse; SHOW with disp_value=15.
- Keys 6,5,5,3,5 then 9 -> A=65535; the 9 is dropped and disp_value stays 65535.
- 8,MUL,2,SUB (ALU returns 16),3,EQ (ALU returns 13) -> second issue has SRC=16, DST=3, ALU_OP=1; final disp_value=13.
- 5,DIV,0,EQ; ALU done with alu_err=1 -> disp_err=1, disp_value=0; digit 7 ignored; CLR -> ENTER_A, disp_err=0.
- alu_done never asserted -> ERROR exactly TIMEOUT cycles after entering WAIT_ALU; CLR during WAIT_ALU -> ENTER_A on timeout, disp_err=0.
- Reset asserted low in WAIT_ALU, then alu_done pulses -> all outputs 0, state ENTER_A, no update from the done.
